// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and the 4x4 key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Entry (row*4 + col), rows top to bottom, columns left to right.
  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pin bundle plus decoded key outputs; master is the scanner side.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, key_release
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, key_release
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column rotation, per-sample debounce of press and
// release on the latched row, registered key code and event pulses.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int COL_CYCLES = 50_000,
  parameter int DB_SAMPLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);
  localparam int                 CNT_W      = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam int                 MATCH_W    = $clog2(DB_SAMPLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(COL_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DB_SAMPLES);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

  logic [3:0]         rs;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MATCH_W-1:0] match_inc;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q, key_held_d;
  logic               key_release_q, key_release_d;
  logic               sample;
  logic               row_low;

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) lowest_low = 2'(i);
    end
  endfunction

  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v);
    return (v == MATCH_FULL) ? v : v + MATCH_ONE;
  endfunction

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.row),
    .q_o (rs)
  );

  assign sample    = (cnt_q == CNT_LAST);
  assign row_low   = ~rs[row_idx_q];
  assign match_inc = sat_inc(match_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      state_q       <= SCAN;
      col_idx_q     <= 2'd0;
      row_idx_q     <= 2'd0;
      match_q       <= '0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      match_q       <= match_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  // Only the latched row is looked at outside SCAN, so a second key is ignored.
  always_comb begin
    cnt_d         = sample ? '0 : cnt_q + CNT_W'(1);
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    match_d       = match_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (rs == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_low(rs);
            match_d   = MATCH_ONE;
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_low) begin
            match_d = match_inc;
            if (match_inc == MATCH_FULL) begin
              state_d     = HELD;
              key_code_d  = key_lookup(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          if (!row_low) begin
            state_d = RELEASE;
            match_d = MATCH_ONE;
          end
        end
        RELEASE: begin
          if (!row_low) begin
            match_d = match_inc;
            if (match_inc == MATCH_FULL) begin
              state_d       = SCAN;
              col_idx_d     = col_idx_q + 2'd1;
              key_release_d = 1'b1;
              key_held_d    = 1'b0;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign kp.col         = ~(4'b0001 << col_idx_q);
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_held    = key_held_q;
  assign kp.key_release = key_release_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: simulated key matrix, sample-level reference model,
// scoreboard of expected press/release events.
module tb_keypad_scan;
  localparam int COLC = 8;
  localparam int DB   = 3;
  localparam int M_IDLE = 0, M_DEB = 1, M_DOWN = 2, M_UP = 3;

  typedef struct {
    bit         rel;
    logic [3:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kif ();

  keypad_scan #(.COL_CYCLES(COLC), .DB_SAMPLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // pm[r][c] = 1 means the key at row r, column c is physically down.
  logic [3:0][3:0] pm = '0;
  logic [3:0]      row_drv;
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) row_drv[r] = ~|(pm[r] & ~kif.col);
  end
  assign kif.row = row_drv;

  int total = 0;
  int bad   = 0;
  ev_t expq[$];

  int         m_st   = M_IDLE;
  int         m_col  = 0;
  int         m_row  = 0;
  int         m_cnt  = 0;
  logic [3:0] m_code = 4'h0;
  bit         m_held = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_value(input int r, input int c);
    string  km;
    byte    ch;
    km = "123A456B789C0FED";
    ch = km[r * 4 + c];
    return (ch >= 65) ? 4'(ch - 55) : 4'(ch - 48);
  endfunction

  function automatic logic [3:0][3:0] key(input int r, input int c);
    key = '0;
    key[r][c] = 1'b1;
  endfunction

  // One sample decision, applied to the matrix held steady for this period.
  task automatic model_step(input logic [3:0][3:0] p);
    logic [3:0] down;
    ev_t        e;
    for (int r = 0; r < 4; r++) down[r] = p[r][m_col];
    case (m_st)
      M_IDLE: begin
        if (down == 4'h0) m_col = (m_col + 1) % 4;
        else begin
          for (int r = 3; r >= 0; r--) if (down[r]) m_row = r;
          m_cnt = 1;
          m_st  = M_DEB;
        end
      end
      M_DEB: begin
        if (down[m_row]) begin
          m_cnt++;
          if (m_cnt >= DB) begin
            m_st   = M_DOWN;
            m_code = key_value(m_row, m_col);
            m_held = 1'b1;
            e.rel  = 1'b0;
            e.code = m_code;
            expq.push_back(e);
          end
        end else begin
          m_st  = M_IDLE;
          m_col = (m_col + 1) % 4;
        end
      end
      M_DOWN: begin
        if (!down[m_row]) begin
          m_st  = M_UP;
          m_cnt = 1;
        end
      end
      default: begin
        if (!down[m_row]) begin
          m_cnt++;
          if (m_cnt >= DB) begin
            m_st   = M_IDLE;
            m_col  = (m_col + 1) % 4;
            m_held = 1'b0;
            e.rel  = 1'b1;
            e.code = m_code;
            expq.push_back(e);
          end
        end else m_st = M_DOWN;
      end
    endcase
  endtask

  // Called on a falling edge; returns on the falling edge after the next sample.
  task automatic period(input logic [3:0][3:0] p);
    logic [3:0] exp_col;
    pm = p;
    exp_col = 4'b1111 ^ (4'b0001 << m_col);
    check("col", 32'(kif.col), 32'(exp_col));
    check("key_held", 32'(kif.key_held), 32'(m_held));
    check("key_code", 32'(kif.key_code), 32'(m_code));
    model_step(p);
    repeat (COLC) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_to(input int c);
    for (int n = 0; n < 8 && m_col != c; n++) period('0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(kif.col), 32'h0000_000E);
    check("rst_code", 32'(kif.key_code), 32'h0);
    check("rst_valid", 32'(kif.key_valid), 32'h0);
    check("rst_held", 32'(kif.key_held), 32'h0);
    check("rst_release", 32'(kif.key_release), 32'h0);
    rst    = 1'b0;
    m_st   = M_IDLE;
    m_col  = 0;
    m_cnt  = 0;
    m_code = 4'h0;
    m_held = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && (kif.key_valid || kif.key_release)) begin
      check("event_pending", 32'(expq.size() > 0), 32'h1);
      if (expq.size() > 0) begin
        ev_t e;
        e = expq.pop_front();
        check("event_kind", 32'({kif.key_release, kif.key_valid}), e.rel ? 32'h2 : 32'h1);
        check("event_code", 32'(kif.key_code), 32'(e.code));
        check("event_held", 32'(kif.key_held), 32'(!e.rel));
      end
    end
  end

  initial begin
    logic [3:0][3:0] pat;
    int              hold;
    pm = '0;
    @(negedge clk);
    do_reset();
    repeat (5) period('0);

    idle_to(1);
    repeat (5) period(key(1, 1));
    repeat (4) period('0);

    idle_to(1);
    repeat (2) period(key(1, 1));
    repeat (2) period('0);

    idle_to(1);
    repeat (3) period(key(1, 1));
    period('0);
    period(key(1, 1));
    repeat (4) period('0);

    idle_to(3);
    repeat (4) period(key(0, 3) | key(2, 3));
    repeat (4) period('0);

    idle_to(1);
    repeat (4) period(key(1, 1));
    do_reset();
    repeat (6) period(key(1, 1));
    repeat (4) period('0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       pat = '0;
        3:       pat = key($urandom_range(0, 3), $urandom_range(0, 3)) |
                       key($urandom_range(0, 3), $urandom_range(0, 3));
        default: pat = key($urandom_range(0, 3), $urandom_range(0, 3));
      endcase
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) period(pat);
    end
    repeat (6) period('0);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
